// File: rtl/riscv_wb_unit.sv
// riscv_wb_unit: writeback arbiter giving ALU results priority over a buffered, extended load-result FIFO.
// Optional RISCV_WB_PERF_EN adds WbCnt_o, a wrapping count of register-file write cycles.
module riscv_wb_unit #(
  parameter int FIFO_DEPTH = 2
) (
`ifdef RISCV_WB_PERF_EN
  output logic [31:0] WbCnt_o,
`endif
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        AluValid_i,
  input  logic [4:0]  AluAddrD_i,
  input  logic [31:0] AluData_i,
  input  logic        LdValid_i,
  output logic        LdReady_o,
  input  logic [4:0]  LdAddrD_i,
  input  logic [31:0] LdData_i,
  input  logic [2:0]  LdFunct3_i,
  input  logic [1:0]  LdByteOff_i,
  output logic        LdStall_o,
  output logic [4:0]  AddrD_o,
  output logic [31:0] DataD_o,
  output logic        RegWEn_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  logic [31:0] data_mem [FIFO_DEPTH];
  logic [4:0]  addr_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d, ext;
  logic          wen_q, wen_d, push, pop;
  logic [7:0]    b;
  logic [15:0]   h;
  assign LdReady_o = !rst_i && (cnt_q < DEPTH_C);
  assign LdStall_o = !LdReady_o;
  assign AddrD_o   = rst_i ? '0 : addr_q;
  assign DataD_o   = rst_i ? '0 : data_q;
  assign RegWEn_o  = !rst_i && wen_q;
  always_comb begin
    b      = LdData_i[{LdByteOff_i, 3'b000} +: 8];
    h      = LdByteOff_i[1] ? LdData_i[31:16] : LdData_i[15:0];
    ext    = LdFunct3_i == 3'b000 ? {{24{b[7]}}, b} :
             LdFunct3_i == 3'b100 ? {24'h0, b} :
             LdFunct3_i == 3'b001 ? {{16{h[15]}}, h} :
             LdFunct3_i == 3'b101 ? {16'h0, h} :
             LdFunct3_i == 3'b010 ? LdData_i : 32'h0;
    push   = LdValid_i && LdReady_o;
    // head is only visible from the registered count, so a fresh enqueue waits a cycle
    pop    = !AluValid_i && cnt_q != '0;
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    addr_d = AluValid_i ? AluAddrD_i : pop ? addr_mem[rptr_q] : addr_q;
    data_d = AluValid_i ? AluData_i : pop ? data_mem[rptr_q] : data_q;
    wen_d  = (AluValid_i || pop) && addr_d != 5'd0;
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wptr_q] <= ext;
      addr_mem[wptr_q] <= LdAddrD_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q  <= wen_d;
    end
  end
`ifdef RISCV_WB_PERF_EN
  logic [31:0] wb_cnt_q, wb_cnt_d;
  assign WbCnt_o = wb_cnt_q;
  always_comb wb_cnt_d = wb_cnt_q + 32'(wen_d);
  always_ff @(posedge clk_i) begin
    if (rst_i) wb_cnt_q <= '0;
    else wb_cnt_q <= wb_cnt_d;
  end
`endif
endmodule

// File: tb/tb_riscv_wb_unit.sv
// tb_riscv_wb_unit: directed table-driven check of load extension, arbitration, ordering and reset.
module tb_riscv_wb_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_v, ld_v, ld_rdy, ld_stall, wen;
  logic [4:0]  alu_rd, ld_rd, addr;
  logic [31:0] alu_d, ld_d, data;
  logic [2:0]  f3;
  logic [1:0]  off;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef RISCV_WB_PERF_EN
  logic [31:0] wb_cnt;
`endif

  riscv_wb_unit #(.FIFO_DEPTH(2)) dut (
`ifdef RISCV_WB_PERF_EN
    .WbCnt_o(wb_cnt),
`endif
    .clk_i(clk), .rst_i(rst),
    .AluValid_i(alu_v), .AluAddrD_i(alu_rd), .AluData_i(alu_d),
    .LdValid_i(ld_v), .LdReady_o(ld_rdy), .LdAddrD_i(ld_rd), .LdData_i(ld_d),
    .LdFunct3_i(f3), .LdByteOff_i(off), .LdStall_o(ld_stall),
    .AddrD_o(addr), .DataD_o(data), .RegWEn_o(wen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        wen;
  } vec_t;
  vec_t v [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic out(input string nm, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({nm, " wen"}, 32'(wen), 32'(w));
    chk({nm, " addr"}, 32'(addr), 32'(a));
    chk({nm, " data"}, data, d);
  endtask

  task automatic alu(input logic vv, input logic [4:0] rd, input logic [31:0] d);
    alu_v = vv; alu_rd = rd; alu_d = d;
  endtask

  task automatic ld(input logic vv, input logic [2:0] fn, input logic [1:0] o, input logic [4:0] rd, input logic [31:0] d);
    ld_v = vv; f3 = fn; off = o; ld_rd = rd; ld_d = d;
  endtask

  initial begin
    v[0]  = '{3'b000, 2'd2, 5'd5,  32'hFFFFFFFF, 1'b1};
    v[1]  = '{3'b000, 2'd0, 5'd6,  32'h00000001, 1'b1};
    v[2]  = '{3'b000, 2'd3, 5'd7,  32'hFFFFFF80, 1'b1};
    v[3]  = '{3'b100, 2'd2, 5'd8,  32'h000000FF, 1'b1};
    v[4]  = '{3'b100, 2'd1, 5'd9,  32'h0000007F, 1'b1};
    v[5]  = '{3'b001, 2'd0, 5'd10, 32'h00007F01, 1'b1};
    v[6]  = '{3'b001, 2'd2, 5'd11, 32'hFFFF80FF, 1'b1};
    v[7]  = '{3'b101, 2'd2, 5'd12, 32'h000080FF, 1'b1};
    v[8]  = '{3'b101, 2'd0, 5'd13, 32'h00007F01, 1'b1};
    v[9]  = '{3'b010, 2'd0, 5'd14, 32'h80FF7F01, 1'b1};
    v[10] = '{3'b011, 2'd0, 5'd15, 32'h00000000, 1'b1};
    v[11] = '{3'b111, 2'd1, 5'd16, 32'h00000000, 1'b1};
    v[12] = '{3'b000, 2'd2, 5'd0,  32'hFFFFFFFF, 1'b0};
    rst = 1'b1;
    alu(0, 0, 0);
    ld(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    out("reset", 0, 0, 0);
    chk("reset ready", 32'(ld_rdy), 0);
    chk("reset stall", 32'(ld_stall), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset ready", 32'(ld_rdy), 1);
    chk("post-reset stall", 32'(ld_stall), 0);

    for (int i = 0; i < 13; i++) begin
      ld(1, v[i].f3, v[i].off, v[i].rd, 32'h80FF7F01);
      @(negedge clk);
      chk($sformatf("vec%0d latency wen", i), 32'(wen), 0);
      ld(0, 0, 0, 0, 0);
      @(negedge clk);
      out($sformatf("vec%0d", i), v[i].wen, v[i].rd, v[i].exp);
    end

    // ALU holds priority for 4 cycles while two loads fill the buffer
    alu(1, 1, 32'hA1); ld(1, 3'b010, 0, 5'd20, 32'h100);
    @(negedge clk);
    out("alu1", 1, 1, 32'hA1);
    chk("ready after 1 load", 32'(ld_rdy), 1);
    alu(1, 2, 32'hA2); ld(1, 3'b010, 0, 5'd21, 32'h200);
    @(negedge clk);
    out("alu2", 1, 2, 32'hA2);
    chk("full ready", 32'(ld_rdy), 0);
    chk("full stall", 32'(ld_stall), 1);
    alu(1, 3, 32'hA3); ld(1, 3'b010, 0, 5'd22, 32'h300);
    @(negedge clk);
    out("alu3", 1, 3, 32'hA3);
    alu(1, 4, 32'hA4); ld(0, 0, 0, 0, 0);
    @(negedge clk);
    out("alu4", 1, 4, 32'hA4);
    chk("still full", 32'(ld_stall), 1);
    alu(0, 0, 0);
    @(negedge clk);
    out("drain ld1", 1, 21 - 1, 32'h100);
    chk("ready after pop", 32'(ld_rdy), 1);
    @(negedge clk);
    out("drain ld2", 1, 21, 32'h200);
    @(negedge clk);
    out("drain idle", 0, 21, 32'h200);

    // back-to-back loads: simultaneous push and pop keep order and count
    ld(1, 3'b010, 0, 5'd23, 32'h11);
    @(negedge clk);
    ld(1, 3'b010, 0, 5'd24, 32'h22);
    @(negedge clk);
    out("stream a", 1, 23, 32'h11);
    chk("stream ready", 32'(ld_rdy), 1);
    ld(1, 3'b010, 0, 5'd25, 32'h33);
    @(negedge clk);
    out("stream b", 1, 24, 32'h22);
    ld(0, 0, 0, 0, 0);
    @(negedge clk);
    out("stream c", 1, 25, 32'h33);
    @(negedge clk);
    out("stream idle", 0, 25, 32'h33);

    alu(1, 0, 32'h1234);
    @(negedge clk);
    out("alu rd0", 0, 0, 32'h1234);
    alu(0, 0, 0);

    // reset discards a buffered load
    alu(1, 7, 32'h77); ld(1, 3'b010, 0, 5'd26, 32'h55);
    @(negedge clk);
    out("pre-reset alu", 1, 7, 32'h77);
    alu(0, 0, 0); ld(0, 0, 0, 0, 0); rst = 1'b1;
    @(negedge clk);
    out("mid reset", 0, 0, 0);
    chk("mid reset ready", 32'(ld_rdy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release ready", 32'(ld_rdy), 1);
    out("release", 0, 0, 0);
    @(negedge clk);
    out("no stale load", 0, 0, 0);

`ifdef RISCV_WB_PERF_EN
    for (int i = 1; i <= 3; i++) begin
      alu(1, 5'(i), 32'(i));
      @(negedge clk);
    end
    alu(0, 0, 0);
    @(negedge clk);
    chk("wb count", wb_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_wb_unit.md
RISCV_WB_UNIT -- requirements
Module: riscv_wb_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk_i, reset port rst_i.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 2, giving the load-result buffer depth; legal values are 2, 4 and 8.
REQ-003 clk_i  input  1  rising-edge clock for all state.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 AluValid_i  input  1  ALU result present this cycle; the ALU path has no backpressure.
REQ-006 AluAddrD_i  input  5  ALU destination register.
REQ-007 AluData_i  input  32  ALU result.
REQ-008 LdValid_i  input  1  load response valid.
REQ-009 LdReady_o  output  1  block can accept a load response.
REQ-010 LdAddrD_i  input  5  load destination register.
REQ-011 LdData_i  input  32  raw aligned memory word.
REQ-012 LdFunct3_i  input  3  load type (RV32I funct3).
REQ-013 LdByteOff_i  input  2  byte offset of the access within the word.
REQ-014 LdStall_o  output  1  upstream issue stall; asserted while the buffer is full.
REQ-015 AddrD_o  output  5  register-file write address.
REQ-016 DataD_o  output  32  register-file write data.
REQ-017 RegWEn_o  output  1  register-file write enable.

Function
REQ-018 A load response SHALL be accepted only in a cycle where LdValid_i=1 and LdReady_o=1.
REQ-019 LdReady_o SHALL be 1 exactly when the buffer count is below FIFO_DEPTH; LdStall_o SHALL equal the inverse of LdReady_o outside reset.
REQ-020 An accepted load SHALL be extended before enqueue, as follows:
- funct3 000 (LB): sign-extended byte LdByteOff_i.
- 100 (LBU): zero-extended byte LdByteOff_i.
- 001 (LH): sign-extended halfword LdByteOff_i[1].
- 101 (LHU): zero-extended halfword LdByteOff_i[1].
- 010 (LW): the full word.
- Any other funct3: data 32'h0.
REQ-021 Arbitration each cycle SHALL be as follows:
- If AluValid_i=1, select the ALU result.
- Else if the buffer is non-empty, select the buffer head and dequeue it.
- Else select nothing.
REQ-022 The selected result SHALL appear on AddrD_o/DataD_o with RegWEn_o=1 exactly one cycle after selection; the latency is 1 cycle.
REQ-023 A selected result with destination 0 SHALL be consumed with RegWEn_o=0; AddrD_o and DataD_o are still updated.
REQ-024 When nothing is selected, RegWEn_o SHALL be 0 and AddrD_o/DataD_o SHALL hold their previous values.
REQ-025 Simultaneous enqueue and dequeue SHALL leave the count unchanged and preserve FIFO order.
REQ-026 Buffer pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 An enqueue into an empty buffer SHALL NOT be selectable in the same cycle; the minimum load-to-write latency is 2 cycles.
REQ-028 Buffer state SHALL be EMPTY, PARTIAL or FULL, with these transitions:
- Enqueue only: count+1.
- Dequeue only: count-1.
- Both, or neither: count unchanged.
REQ-029 Loads SHALL always be written back in acceptance order.

Reset
REQ-030 While rst_i=1, outputs SHALL be: AddrD_o=0, DataD_o=0, RegWEn_o=0, LdReady_o=0, LdStall_o=1.
REQ-031 While rst_i=1, the buffer SHALL be emptied and its pointers zeroed.
REQ-032 Reset asserted mid-operation SHALL discard all buffered loads without writing them back.
REQ-033 In the first cycle after reset deassertion, LdReady_o SHALL be 1 and LdStall_o 0.

Configuration
REQ-034 With macro RISCV_WB_PERF_EN defined, the block SHALL add port WbCnt_o (output, 32 bits): a count of cycles with RegWEn_o=1, reset to 0, wrapping from 32'hFFFFFFFF to 0.
REQ-035 Without RISCV_WB_PERF_EN, port WbCnt_o and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 LB response, LdData_i=32'h80FF7F01, LdByteOff_i=2, rd=5, no ALU -> two cycles later RegWEn_o=1, AddrD_o=5, DataD_o=32'hFFFFFFFF.
REQ-037 LHU on the same word with LdByteOff_i=2 -> DataD_o=32'h000080FF; LW -> 32'h80FF7F01; funct3=011 -> 32'h0.
REQ-038 AluValid_i held high 4 cycles while 2 loads arrive (FIFO_DEPTH=2):
- Expected: LdReady_o=0 and LdStall_o=1 after the second accept.
- Expected: the ALU results are written on consecutive cycles.
- Expected: the loads are written in order once AluValid_i drops.
REQ-039 ALU result with rd=0, data 32'h1234 -> the next cycle RegWEn_o=0 and AddrD_o=0.
REQ-040 rst_i asserted with one load buffered -> no write of that load; after release LdReady_o=1 and RegWEn_o=0.
REQ-041 With RISCV_WB_PERF_EN defined, 3 non-zero-rd writes -> WbCnt_o=3; with the counter preloaded to 32'hFFFFFFFF, one write -> WbCnt_o=0.
